// File: rtl/text_pkg.sv
// text_pkg: shared constants and types for the character-cell text buffer.
//   TEXT_COLS/TEXT_ROWS : default grid size (80x30 cells of 8x16 pixels at 640x480)
//   ASC_*               : control codes interpreted by the write port, plus the blank code
//   state_e             : write-side sequencer states
//   is_printable        : true for codes that get written into a cell
package text_pkg;

  localparam int unsigned TEXT_COLS = 80;
  localparam int unsigned TEXT_ROWS = 30;

  localparam logic [6:0] ASC_BS    = 7'h08;
  localparam logic [6:0] ASC_LF    = 7'h0A;
  localparam logic [6:0] ASC_FF    = 7'h0C;
  localparam logic [6:0] ASC_CR    = 7'h0D;
  localparam logic [6:0] ASC_BLANK = 7'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2
  } state_e;

  function automatic logic is_printable(logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_ram.sv
// text_ram: simple dual-port cell store, one synchronous write port and one registered
// read port. No reset on the array so synthesis maps it onto block RAM.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr          : read address, o_rdata valid one cycle later
//   o_rdata          : registered read data (old contents on a same-cycle write)
module text_ram #(
  parameter int unsigned Depth = 2400,
  parameter int unsigned AddrW = 12,
  parameter int unsigned Width = 7
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character-cell store and cursor engine feeding the glyph lookup.
//   i_clk, i_rst_n          : pixel clock, asynchronous active-low reset
//   i_wr_valid/o_wr_ready   : write handshake, i_wr_char sampled on accept
//   i_wr_char               : ASCII code to store or interpret (LF, CR, BS, FF)
//   i_x, i_y                : current pixel from the sync generator
//   o_ascii                 : code of the cell under (x, y), one cycle later
//   o_cursor_col/row        : position of the next write
//   o_busy                  : high while a line or screen clear runs
module text_buffer
  import text_pkg::*;
#(
  parameter int unsigned COLS  = TEXT_COLS,
  parameter int unsigned ROWS  = TEXT_ROWS,
  parameter logic [6:0]  BLANK = ASC_BLANK
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [6:0] i_wr_char,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic [6:0] o_ascii,
  output logic [6:0] o_cursor_col,
  output logic [4:0] o_cursor_row,
  output logic       o_busy
);

  localparam int unsigned Cells    = COLS * ROWS;
  localparam logic [6:0]  ColLast  = 7'(COLS - 1);
  localparam logic [4:0]  RowLast  = 5'(ROWS - 1);
  localparam logic [11:0] CellLast = 12'(Cells - 1);
  localparam logic [11:0] ColsW    = 12'(COLS);
  localparam logic [11:0] LineLast = 12'(COLS - 1);

  state_e      r_state, w_state_d;
  logic [6:0]  r_col, w_col_d;
  logic [4:0]  r_row, w_row_d;
  logic [11:0] r_clr_cnt, w_clr_cnt_d;
  logic        r_blank;

  logic        w_accept;
  logic [4:0]  w_row_next;
  logic [11:0] w_line_base;
  logic [11:0] w_cur_addr;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [6:0]  w_wdata;

  logic [6:0]  w_rd_col;
  logic [5:0]  w_rd_row;
  logic        w_off_grid;
  logic [11:0] w_raddr;
  logic [6:0]  w_ram_rdata;
  logic        w_unused_pix;

  assign o_wr_ready   = (r_state == IDLE);
  assign o_busy       = ~o_wr_ready;
  assign o_cursor_col = r_col;
  assign o_cursor_row = r_row;

  assign w_accept    = i_wr_valid && o_wr_ready;
  // No scrolling: the row after the last one is row 0, which then gets cleared.
  assign w_row_next  = (r_row == RowLast) ? 5'd0 : r_row + 5'd1;
  assign w_line_base = 12'(r_row) * ColsW;
  assign w_cur_addr  = w_line_base + 12'(r_col);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= CLEAR_ALL;
      r_col     <= '0;
      r_row     <= '0;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_col     <= w_col_d;
      r_row     <= w_row_d;
      r_clr_cnt <= w_clr_cnt_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_col_d     = r_col;
    w_row_d     = r_row;
    w_clr_cnt_d = r_clr_cnt;
    w_we        = 1'b0;
    w_waddr     = w_cur_addr;
    w_wdata     = BLANK;
    unique case (r_state)
      CLEAR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        if (r_clr_cnt == CellLast) begin
          w_state_d   = IDLE;
          w_clr_cnt_d = '0;
        end else begin
          w_clr_cnt_d = r_clr_cnt + 12'd1;
        end
      end
      CLEAR_LINE: begin
        // Cursor already points at the row being cleared.
        w_we    = 1'b1;
        w_waddr = w_line_base + r_clr_cnt;
        if (r_clr_cnt == LineLast) begin
          w_state_d   = IDLE;
          w_clr_cnt_d = '0;
        end else begin
          w_clr_cnt_d = r_clr_cnt + 12'd1;
        end
      end
      IDLE: begin
        if (w_accept) begin
          if (is_printable(i_wr_char)) begin
            w_we    = 1'b1;
            w_wdata = i_wr_char;
            if (r_col == ColLast) begin
              w_col_d     = '0;
              w_row_d     = w_row_next;
              w_state_d   = CLEAR_LINE;
              w_clr_cnt_d = '0;
            end else begin
              w_col_d = r_col + 7'd1;
            end
          end else begin
            case (i_wr_char)
              ASC_LF: begin
                w_col_d     = '0;
                w_row_d     = w_row_next;
                w_state_d   = CLEAR_LINE;
                w_clr_cnt_d = '0;
              end
              ASC_CR: w_col_d = '0;
              ASC_BS: begin
                if (r_col != 7'd0) begin
                  w_col_d = r_col - 7'd1;
                  w_we    = 1'b1;
                  w_waddr = w_cur_addr - 12'd1;
                end
              end
              ASC_FF: begin
                w_col_d     = '0;
                w_row_d     = '0;
                w_state_d   = CLEAR_ALL;
                w_clr_cnt_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        w_state_d   = CLEAR_ALL;
        w_clr_cnt_d = '0;
      end
    endcase
  end

  // Read side: off-grid pixels are masked after the RAM instead of addressing it.
  assign w_rd_col     = i_x[9:3];
  assign w_rd_row     = i_y[9:4];
  assign w_off_grid   = (w_rd_col > ColLast) || (w_rd_row > {1'b0, RowLast});
  assign w_raddr      = w_off_grid ? 12'd0 : (12'(w_rd_row) * ColsW + 12'(w_rd_col));
  assign w_unused_pix = ^{i_x[2:0], i_y[3:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blank <= 1'b1;
    end else begin
      r_blank <= w_off_grid;
    end
  end

  text_ram #(
    .Depth(Cells),
    .AddrW(12),
    .Width(7)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_rdata)
  );

  assign o_ascii = r_blank ? BLANK : w_ram_rdata;

endmodule

// File: tb/tb_text_buffer.sv
module tb_text_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [6:0] BLANK = 7'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_char = 7'h00;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic       wr_ready;
  logic [6:0] ascii;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  always #5 clk = ~clk;

  text_buffer u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_char   (wr_char),
    .i_x         (x),
    .i_y         (y),
    .o_ascii     (ascii),
    .o_cursor_col(cursor_col),
    .o_cursor_row(cursor_row),
    .o_busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference screen and cursor.
  logic [6:0] scr [ROWS][COLS];
  int m_col = 0;
  int m_row = 0;

  typedef struct {
    logic [6:0] exp;
    int         px;
    int         py;
  } rd_t;
  rd_t exp_q[$];
  logic rd_req = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a read requested before an edge is compared after that edge.
  initial begin : monitor
    logic req;
    rd_t  e;
    forever begin
      @(posedge clk);
      req = rd_req;
      @(negedge clk);
      if (req) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_empty: got ascii %0h expected a queued entry", ascii);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (ascii !== e.exp) begin
            n_err++;
            $display("FAIL ascii(x=%0d,y=%0d): got %0h expected %0h", e.px, e.py, ascii, e.exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic model_clear_row(input int r);
    for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
  endtask

  task automatic model_clear_all();
    for (int r = 0; r < ROWS; r++) model_clear_row(r);
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_apply(input logic [6:0] c, output int busy_exp);
    busy_exp = 0;
    if (c >= 7'h20 && c <= 7'h7E) begin
      scr[m_row][m_col] = c;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        model_clear_row(m_row);
        busy_exp = COLS;
      end
    end else if (c == 7'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      model_clear_row(m_row);
      busy_exp = COLS;
    end else if (c == 7'h0D) begin
      m_col = 0;
    end else if (c == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        scr[m_row][m_col] = BLANK;
      end
    end else if (c == 7'h0C) begin
      model_clear_all();
      busy_exp = COLS * ROWS;
    end
  endtask

  function automatic logic [6:0] model_read(input int px, input int py);
    int c;
    int r;
    c = px / 8;
    r = py / 16;
    if (c >= COLS || r >= ROWS) return BLANK;
    return scr[r][c];
  endfunction

  // All stimulus tasks start and end just after a falling edge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 6000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_px(input int px, input int py);
    rd_t e;
    x = 10'(px);
    y = 10'(py);
    rd_req = 1'b1;
    e.exp = model_read(px, py);
    e.px = px;
    e.py = py;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic end_reads();
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic scan_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        read_px(c * 8 + int'($urandom_range(0, 7)), r * 16 + int'($urandom_range(0, 15)));
    end_reads();
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++)
      read_px(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
    end_reads();
  endtask

  task automatic send_char(input logic [6:0] c, input bit wait_done);
    int guard;
    int busy_exp;
    int n;
    guard = 0;
    wr_valid = 1'b1;
    wr_char = 7'($urandom);
    // Changing wr_char while not ready must have no effect.
    while (!wr_ready && guard < 6000) begin
      @(negedge clk);
      wr_char = 7'($urandom);
      guard++;
    end
    if (!wr_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got wr_ready 0 expected 1 within 6000 cycles");
      wr_valid = 1'b0;
      return;
    end
    wr_char = c;
    @(posedge clk);
    model_apply(c, busy_exp);
    @(negedge clk);
    wr_valid = 1'b0;
    check("cursor_col", cursor_col, m_col);
    check("cursor_row", cursor_row, m_row);
    if (wait_done) begin
      wait_idle(n);
      check("busy_cycles", n, busy_exp);
    end
  endtask

  task automatic reset_release_and_check();
    int n;
    wr_valid = 1'b1;
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 6000) begin
      n++;
      @(negedge clk);
      wr_char = 7'($urandom);
    end
    wr_valid = 1'b0;
    check("reset_clear_cycles", n, COLS * ROWS);
    check("reset_cursor_col", cursor_col, 0);
    check("reset_cursor_row", cursor_row, 0);
    model_clear_all();
  endtask

  logic [6:0] rc;
  int rsel;

  initial begin : stim
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ascii", ascii, BLANK);
    check("rst_busy", busy, 1);
    check("rst_ready", wr_ready, 0);
    check("rst_cursor_col", cursor_col, 0);
    check("rst_cursor_row", cursor_row, 0);
    reset_release_and_check();
    scan_all();

    // "FPGA" on row 0.
    send_char(7'h46, 1'b1);
    send_char(7'h50, 1'b1);
    send_char(7'h47, 1'b1);
    send_char(7'h41, 1'b1);
    check("fpga_col", cursor_col, 4);
    for (int i = 0; i < 16; i++) read_px(i % 8, i);
    for (int i = 0; i < 16; i++) read_px(24 + i % 8, 15 - i);
    end_reads();

    // Full line from column 0 wraps and clears row 1.
    send_char(7'h0D, 1'b1);
    for (int i = 0; i < COLS; i++) send_char(7'($urandom_range(32, 126)), 1'b1);
    check("line_wrap_row", cursor_row, 1);
    check("line_wrap_col", cursor_col, 0);
    scan_all();

    // Random mix of printables and control codes.
    for (int i = 0; i < 240; i++) begin
      rsel = int'($urandom_range(0, 99));
      if (rsel < 70) rc = 7'($urandom_range(32, 126));
      else if (rsel < 77) rc = 7'h0D;
      else if (rsel < 84) rc = 7'h08;
      else if (rsel < 90) rc = 7'h0A;
      else if (rsel < 93) rc = 7'h7F;
      else begin
        rc = 7'($urandom_range(0, 31));
        if (rc == 7'h0C) rc = 7'h07;
      end
      send_char(rc, 1'b1);
      if (i % 60 == 59) rand_reads(80);
    end
    scan_all();

    // LF from the last row wraps to row 0 and clears it.
    while (m_row != ROWS - 1) send_char(7'h0A, 1'b1);
    send_char(7'h48, 1'b1);
    send_char(7'h49, 1'b1);
    send_char(7'h0A, 1'b1);
    check("lf_wrap_row", cursor_row, 0);
    check("lf_wrap_col", cursor_col, 0);
    scan_all();

    // Backspace, backspace at column 0, and a dropped control code.
    send_char(7'h41, 1'b1);
    send_char(7'h08, 1'b1);
    send_char(7'h08, 1'b1);
    send_char(7'h07, 1'b1);
    check("bs_col", cursor_col, 0);
    for (int i = 0; i < 8; i++) read_px(i, i * 2);
    end_reads();

    // Off-grid pixels.
    for (int i = 0; i < 40; i++) read_px(int'($urandom_range(640, 799)), int'($urandom_range(0, 524)));
    for (int i = 0; i < 40; i++) read_px(int'($urandom_range(0, 799)), int'($urandom_range(480, 524)));
    end_reads();

    // Form feed mid-screen.
    send_char(7'h0A, 1'b1);
    send_char(7'h0A, 1'b1);
    for (int i = 0; i < 10; i++) send_char(7'($urandom_range(32, 126)), 1'b1);
    send_char(7'h0C, 1'b1);
    scan_all();

    // Reset pulse in the middle of a line clear.
    for (int i = 0; i < 5; i++) send_char(7'($urandom_range(32, 126)), 1'b1);
    send_char(7'h0A, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midclr_rst_cursor_row", cursor_row, 0);
    check("midclr_rst_busy", busy, 1);
    check("midclr_rst_ascii", ascii, BLANK);
    reset_release_and_check();
    scan_all();
    send_char(7'h5A, 1'b1);
    rand_reads(50);
    read_px(3, 5);
    end_reads();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
# text_buffer

Character-cell store and cursor engine that sits directly upstream of the per-pixel glyph lookup in the VGA text pipeline. Accepts a stream of 7-bit ASCII characters over a valid/ready write port, interprets a small set of control codes, and maintains an 80x30 grid of cells for 8x16 glyphs at 640x480. On its read side it maps the current pixel (x, y) to that cell's ASCII code with one cycle of latency. The font ROM stage consumes this code as the upper address bits.

## Interface
- COLS, 80, number of character columns (x[9:3] indexes them)
- ROWS, 30, number of character rows (y[9:4] indexes them)
- BLANK, 7'h20, code written by clears and returned for off-grid pixels
- clk  input  1  pixel clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- wr_valid  input  1  wr_char is presented
- wr_ready  output  1  block can accept a character this cycle
- wr_char  input  7  ASCII code to write or interpret
- x  input  10  current pixel column from the sync generator
- y  input  10  current pixel row from the sync generator
- ascii  output  7  cell code for (x, y), registered
- cursor_col  output  7  column of the next write
- cursor_row  output  5  row of the next write
- busy  output  1  high while a line or screen clear is in progress

## Operation
- States: CLEAR_ALL, IDLE, CLEAR_LINE.
- wr_ready = (state == IDLE); busy = !wr_ready. A transfer occurs on an edge where wr_valid && wr_ready.
- CLEAR_ALL writes BLANK to every cell, one per cycle, in address order row*COLS+col. After the last cell: IDLE, with the cursor at (0,0).
- CLEAR_LINE writes BLANK to the COLS cells of cursor_row, then goes to IDLE.
- Printable codes 0x20–0x7E: write to (cursor_row, cursor_col), then advance the column.
  - If cursor_col was COLS-1: col←0, row←next, enter CLEAR_LINE.
  - next(r) = r+1, or 0 when r = ROWS-1. There is no scrolling; the wrapped row is cleared.
- 0x0A LF: col←0, row←next, enter CLEAR_LINE.
- 0x0D CR: col←0, no write.
- 0x08 BS:
  - If col>0: col←col-1, and write BLANK at the new column in the same cycle.
  - If col=0: accepted, no effect.
- 0x0C FF: enter CLEAR_ALL and reset the clear counter. The cursor goes to (0,0) immediately.
- All other codes (0x00–0x1F not listed, and 0x7F) are accepted and dropped, with no state change.
- Read side:
  - cell col = x[9:3], row = y[9:4].
  - If col ≥ COLS or row ≥ ROWS, the next ascii is BLANK; otherwise it is the stored code.
  - The read port is independent of the write port and is never stalled by clears.
- Same-cycle read and write of one cell: the read returns the old contents.

## Timing
- Reset (asynchronous assert, synchronous release) puts the block in:
  - state CLEAR_ALL, wr_ready=0, busy=1
  - ascii=BLANK, cursor_col=0, cursor_row=0
  - clear counter = 0
- The RAM is not reset. The first IDLE cycle is exactly COLS*ROWS = 2400 cycles after reset release.
- Read latency: ascii is valid 1 cycle after (x, y). The downstream stage delays x[2:0] and y[3:0] by one cycle to align with it.
- A character accepted on edge N is visible through the read port for (x, y) presented on cycle N+1 or later.
- Cursor outputs update on the accept edge.
- CLEAR_LINE occupies exactly COLS cycles. FF occupies COLS*ROWS cycles. wr_ready rises in the cycle after the last clear write.
- Reset asserted mid-clear or mid-transfer aborts the operation and restarts CLEAR_ALL from cell 0. A partially written RAM is acceptable because it is fully overwritten.
- wr_char is sampled only on an accept edge. A held wr_valid with a changing wr_char while wr_ready=0 has no effect.

## Structure
- Shared package text_pkg:
  - ASCII constants ASC_LF, ASC_CR, ASC_BS, ASC_FF, ASC_BLANK
  - the state enum (CLEAR_ALL, IDLE, CLEAR_LINE)
  - TEXT_COLS/TEXT_ROWS defaults
- Sub-module text_ram:
  - simple dual-port, COLS*ROWS x 7
  - one synchronous write port, one registered read port
  - written so synthesis infers block RAM
- The address is row*COLS+col, computed with 12-bit arithmetic.

## Test plan
- Reset, hold wr_valid=1 → wr_ready=0 for 2400 cycles, then 1; ascii=7'h20 at every (x, y) scan.
- Write 'F','P','G','A' (0x46,0x50,0x47,0x41) → cursor=(0,4); pixels (0..7,0..15) read 0x46 and (24..31,0..15) read 0x41, one cycle late.
- Write 80 printable chars from (0,0) → cursor=(1,0); busy high for exactly 80 cycles; row 1 all 0x20.
- At row 29 send LF → cursor=(0,0), row 0 cleared to 0x20; rows 1–29 unchanged.
- Send 0x41, BS, BS → cell (0,0)=0x20, cursor=(0,0); BS at col 0 accepted with no change. Send 0x07 → dropped.
- Pixels x=640..799 or y=480..524 → ascii=0x20. FF mid-screen → busy for 2400 cycles. Reset pulse mid-CLEAR_LINE → restarts the 2400-cycle CLEAR_ALL.
